// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/
// memory/writeback and drives the datapath selects, write enables and ALU opcode.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUcontrol,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:  if (MemReady) cur <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYPE:     cur <= EXEC;
                        OP_BEQ:       cur <= BRANCH;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR: begin
                    // the IR is stable here, so Op can be re-decoded to pick read vs write
                    if (Op == OP_LW)      cur <= MEMRD;
                    else if (Op == OP_SW) cur <= MEMWR;
                    else                  cur <= FETCH;
                end
                MEMRD:  if (MemReady) cur <= MEMWB;
                MEMWR:  if (MemReady) cur <= FETCH;
                EXEC:   cur <= ALUWB;
                ADDIEX: cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUcontrol = 3'b010;
        PCSrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (cur)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                pcwrite = MemReady;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = MemReady;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100000: ALUcontrol = 3'b010;
                    6'b100010: ALUcontrol = 3'b110;
                    6'b100100: ALUcontrol = 3'b000;
                    6'b100101: ALUcontrol = 3'b001;
                    6'b101010: ALUcontrol = 3'b111;
                    default:   ALUcontrol = 3'b010;
                endcase
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = 3'b110;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            JUMP: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        PCEn = pcwrite | (branch & zero);
        // reset kills any in-flight write immediately, not just at the next edge
        if (!rst_n) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUcontrol = 3'b010;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction table, hand-written corner cases
// and random instruction streams checked against a per-instruction trace model.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op, Funct;
    logic       zero, MemReady;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUcontrol;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .zero(zero),
        .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUcontrol(ALUcontrol), .PCSrc(PCSrc), .PCEn(PCEn),
        .state(state)
    );

    always #5 clk = ~clk;

    localparam bit [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam bit [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    // one expected clock cycle: inputs to apply and outputs to see
    typedef struct {
        bit       mr, z;
        bit [3:0] st;
        bit       iord, mw, irw, rdst, m2r, rw, srca;
        bit [1:0] srcb;
        bit [2:0] alu;
        bit [1:0] pcsrc;
        bit       pcen;
    } cyc_t;

    cyc_t exp_q[$];

    wire [14:0] outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                        ALUSrcB, ALUcontrol, PCSrc, PCEn};

    function automatic logic [14:0] pack(cyc_t c);
        return {c.iord, c.mw, c.irw, c.rdst, c.m2r, c.rw, c.srca, c.srcb, c.alu, c.pcsrc, c.pcen};
    endfunction

    function automatic cyc_t blank(bit [3:0] st, bit mr, bit z);
        cyc_t c;
        c = '{default: 0};
        c.st = st; c.mr = mr; c.z = z; c.alu = 3'b010;
        return c;
    endfunction

    function automatic bit [2:0] alu_of(bit [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected cycle trace of one instruction; wf/wm = MemReady-low cycles on fetch / data access.
    function automatic void build(bit [5:0] op, bit [5:0] funct, bit z, int wf, int wm);
        cyc_t c;
        for (int i = 0; i <= wf; i++) begin
            c = blank(4'd0, i == wf, z); c.srcb = 2'b01; c.irw = (i == wf); c.pcen = (i == wf);
            exp_q.push_back(c);
        end
        c = blank(4'd1, rb(), z); c.srcb = 2'b11; exp_q.push_back(c);
        if (op == LW || op == SW) begin
            c = blank(4'd2, rb(), z); c.srca = 1; c.srcb = 2'b10; exp_q.push_back(c);
            for (int i = 0; i <= wm; i++) begin
                c = blank(op == LW ? 4'd3 : 4'd5, i == wm, z); c.iord = 1;
                c.mw = (op == SW) && (i == wm);
                exp_q.push_back(c);
            end
            if (op == LW) begin
                c = blank(4'd4, rb(), z); c.m2r = 1; c.rw = 1; exp_q.push_back(c);
            end
        end else if (op == R) begin
            c = blank(4'd6, rb(), z); c.srca = 1; c.alu = alu_of(funct); exp_q.push_back(c);
            c = blank(4'd7, rb(), z); c.rdst = 1; c.rw = 1; exp_q.push_back(c);
        end else if (op == BEQ) begin
            c = blank(4'd8, rb(), z); c.srca = 1; c.alu = 3'b110; c.pcsrc = 2'b01; c.pcen = z;
            exp_q.push_back(c);
        end else if (op == ADDI) begin
            c = blank(4'd9, rb(), z); c.srca = 1; c.srcb = 2'b10; exp_q.push_back(c);
            c = blank(4'd10, rb(), z); c.rw = 1; exp_q.push_back(c);
        end else if (op == J) begin
            c = blank(4'd11, rb(), z); c.pcsrc = 2'b10; c.pcen = 1; exp_q.push_back(c);
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic run_q(int n);
        for (int i = 0; i < n; i++) begin
            MemReady = exp_q[i].mr;
            zero     = exp_q[i].z;
            #1;
            check("state", 32'(state), 32'(exp_q[i].st));
            check("outputs", 32'(outs), 32'(pack(exp_q[i])));
            @(negedge clk);
        end
    endtask

    task automatic run_instr(bit [5:0] op, bit [5:0] funct, bit z, int wf, int wm);
        Op = op; Funct = funct;
        exp_q.delete();
        build(op, funct, z, wf, wm);
        run_q(exp_q.size());
        exp_q.delete();
    endtask

    // table: instruction, cycle count with MemReady=1, and a key value (ALU code in EXEC, PCEn in BRANCH/JUMP)
    typedef struct {
        bit [5:0] op, funct;
        bit       z;
        int       ncyc;
        bit [2:0] key;
    } vec_t;

    vec_t tbl[13];
    bit [5:0] ops[7];
    bit [5:0] functs[5];

    initial begin
        int n;
        bit [2:0] key;
        tbl[0]  = '{R,    6'b100000, 0, 4, 3'b010};
        tbl[1]  = '{R,    6'b100010, 0, 4, 3'b110};
        tbl[2]  = '{R,    6'b100100, 0, 4, 3'b000};
        tbl[3]  = '{R,    6'b100101, 0, 4, 3'b001};
        tbl[4]  = '{R,    6'b101010, 0, 4, 3'b111};
        tbl[5]  = '{R,    6'b111111, 0, 4, 3'b010};
        tbl[6]  = '{LW,   6'b000000, 0, 5, 3'b000};
        tbl[7]  = '{SW,   6'b000000, 0, 4, 3'b000};
        tbl[8]  = '{ADDI, 6'b000000, 0, 4, 3'b000};
        tbl[9]  = '{BEQ,  6'b000000, 1, 3, 3'b001};
        tbl[10] = '{BEQ,  6'b000000, 0, 3, 3'b000};
        tbl[11] = '{J,    6'b000000, 0, 3, 3'b001};
        tbl[12] = '{6'b111111, 6'b000000, 0, 2, 3'b000};
        ops    = '{R, LW, SW, BEQ, ADDI, J, 6'b111111};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rst_n = 0; MemReady = 1; zero = 0; Op = 0; Funct = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_state", 32'(state), 32'd0);
            check("rst_outputs", 32'(outs), 32'(pack(blank(4'd0, 1, 0))));
            @(negedge clk);
        end
        rst_n = 1;
        #1;
        check("release_irwrite", 32'(IRWrite), 32'd1);
        check("release_pcen", 32'(PCEn), 32'd1);

        for (int t = 0; t < 13; t++) begin
            Op = tbl[t].op; Funct = tbl[t].funct; zero = tbl[t].z; MemReady = 1;
            n = 1; key = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk); #1;
                if (state == 4'd0) break;
                n++;
                if (state == 4'd6) key = ALUcontrol;
                if (state == 4'd8 || state == 4'd11) key = {2'b00, PCEn};
            end
            check("tbl_cycles", 32'(n), 32'(tbl[t].ncyc));
            check("tbl_key", 32'(key), 32'(tbl[t].key));
        end

        run_instr(LW, 6'd0, 0, 0, 2);
        run_instr(SW, 6'd0, 0, 0, 1);
        run_instr(BEQ, 6'd0, 1, 1, 0);
        run_instr(BEQ, 6'd0, 0, 0, 0);
        run_instr(J, 6'd0, 0, 2, 0);
        run_instr(6'b111111, 6'd0, 0, 0, 0);

        // reset asserted during MEMWB must suppress the register write
        Op = LW; Funct = 0;
        exp_q.delete();
        build(LW, 6'd0, 0, 0, 0);
        run_q(exp_q.size() - 1);
        exp_q.delete();
        MemReady = 1; rst_n = 0;
        #1;
        check("midrst_state", 32'(state), 32'd4);
        check("midrst_regwrite", 32'(RegWrite), 32'd0);
        @(negedge clk); #1;
        check("midrst_next_state", 32'(state), 32'd0);
        rst_n = 1;

        for (int r = 0; r < 80; r++) begin
            bit [5:0] op, fn;
            op = ops[$urandom_range(0, 6)];
            if (r % 8 == 7) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 5) == 5) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
            run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath mux selects and write enables, and generates the 3-bit `ALUcontrol` code consumed directly by the ALU. Takes the ALU `zero` flag back to resolve `beq`.

## Interface
Parameters: none (encodings fixed below).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `Op` input 6: instruction[31:26] from the instruction register.
- `Funct` input 6: instruction[5:0].
- `zero` input 1: ALU zero flag.
- `MemReady` input 1: memory completes the current access this cycle.
- `IorD` output 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite` output 1: data memory write enable.
- `IRWrite` output 1: instruction register load.
- `RegDst` output 1: write register select (0 = rt, 1 = rd).
- `MemtoReg` output 1: writeback data select (0 = ALUOut, 1 = Data).
- `RegWrite` output 1: register file write enable.
- `ALUSrcA` output 1: SrcA select (0 = PC, 1 = A).
- `ALUSrcB` output 2: SrcB select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `ALUcontrol` output 3: ALU operation code.
- `PCSrc` output 2: next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `PCEn` output 1: PC load enable.
- `state` output 4: current state, for debug.

## Operation
- States, 4-bit encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Transitions:
  - FETCH→DECODE when MemReady=1, else stay in FETCH.
  - DECODE→ by Op: MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j).
  - DECODE with any other Op → FETCH. The instruction is a NOP; no write enable is asserted.
  - MEMADR→MEMRD (lw) or MEMWR (sw); Op is re-checked here.
  - MEMRD→MEMWB when MemReady=1, else stay in MEMRD.
  - MEMWR→FETCH when MemReady=1, else stay in MEMWR.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
- Outputs are Moore (decoded from state), except the MemReady gating and PCEn noted below. Any signal not listed for a state is 0.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUcontrol=010.
    - IRWrite=MemReady; PCWrite=MemReady.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUcontrol=010.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUcontrol=010.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=MemReady.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUcontrol decoded from Funct:
    - 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
    - Any other Funct→010.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUcontrol=110, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & zero). This is combinational in `zero`, valid within the same cycle.
- ALUcontrol defaults to 010 in states where the ALU result is unused.

## Timing
- Reset: when rst_n=0 at a rising edge, state←FETCH.
  - While rst_n=0, all write enables (MemWrite, IRWrite, RegWrite, PCEn) are forced to 0 combinationally.
  - All selects read 0, ALUcontrol reads 010, and `state` reads 0 at the first edge.
- Reset mid-instruction abandons it. No writeback occurs after reset is asserted.
- Cycle counts with MemReady held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal Op 2.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
  - IRWrite, PCWrite and MemWrite pulse exactly once per access, in the MemReady=1 cycle.
- Op and Funct are sampled in the DECODE, MEMADR and EXEC cycles. The IR is stable then, since IRWrite is 0 outside FETCH.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with MemReady=1 → state=0 and all enables 0 throughout. Release → IRWrite=PCEn=1 in the first cycle.
- R-type sweep: Op=000000 with Funct in {100000, 100010, 100100, 100101, 101010, 111111} → state sequence 0,1,6,7,0.
  - ALUcontrol in EXEC = 010, 110, 000, 001, 111, 010 respectively.
  - RegWrite=1 and RegDst=1 in ALUWB only.
- lw with MemReady low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0. RegWrite=1 and MemtoReg=1 in state 4 only.
- sw with MemReady=0 on the first MEMWR cycle → MemWrite=0 then 1, each exactly once. No RegWrite is asserted.
- beq:
  - zero=1 in BRANCH → PCEn=1, PCSrc=01, ALUcontrol=110.
  - zero=0 → PCEn=0.
  - Both cases → 3 cycles total.
- j → sequence 0,1,11,0 with PCSrc=10 and PCEn=1 in JUMP.
- Op=111111 → 0,1,0 with no enables asserted in DECODE.
- rst_n=0 asserted during MEMWB → RegWrite=0 that cycle, state=0 next.
